// File: rtl/uart_bfm_pkg.sv
// Shared constants for the 8N1 UART bench peer: frame geometry and FSM state encodings.
package uart_bfm_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam logic [7:0]  ASCII_LF  = 8'h0A;

   // TX FSM state encodings
   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   // RX FSM state encodings
   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

endpackage : uart_bfm_pkg

// File: rtl/uart_txrx_bfm_if.sv
// Bench-facing bundle of the UART peer: serial lines plus the TX request and RX result handshakes.
interface uart_txrx_bfm_if;
   import uart_bfm_pkg::*;

   logic                 ser_rx;
   logic                 ser_tx;
   logic                 tx_start;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_busy;
   logic                 tx_clear_req;
   logic                 rx_finish;
   logic [DATA_BITS-1:0] rx_byte;

   // UART peer side
   modport slave (
      input  ser_rx, tx_start, tx_data,
      output ser_tx, tx_busy, tx_clear_req, rx_finish, rx_byte
   );

   // Bench / requester side
   modport master (
      output ser_rx, tx_start, tx_data,
      input  ser_tx, tx_busy, tx_clear_req, rx_finish, rx_byte
   );

endinterface : uart_txrx_bfm_if

// File: rtl/uart_bfm_rx.sv
// 8N1 receiver: 2-flop synchronizer, glitch-filtered start detect, mid-bit sampling.
module uart_bfm_rx
   import uart_bfm_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4167
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ser_rx_i,
   output logic                 rx_finish_o,
   output logic [DATA_BITS-1:0] rx_byte_o
);

   localparam int unsigned    CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam int unsigned    IDX_W     = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic                 sync1_q, sync2_q, prev_q;
   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 rx_finish_q, rx_finish_d;
   logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;

   // Synchronize the asynchronous line and keep one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= ser_rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // RX state and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         rx_finish_q <= 1'b0;
         rx_byte_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         rx_finish_q <= rx_finish_d;
         rx_byte_q   <= rx_byte_d;
      end
   end

   // Next state: half-bit check of the start bit, then full-bit spacing to stay at mid-bit
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      idx_d       = idx_q;
      shreg_d     = shreg_q;
      rx_finish_d = 1'b0;
      rx_byte_d   = rx_byte_q;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (prev_q && !sync2_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) state_d = RX_STOP;
               else                   idx_d   = idx_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               if (sync2_q) begin
                  rx_byte_d   = shreg_q;
                  rx_finish_d = 1'b1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign rx_finish_o = rx_finish_q;
   assign rx_byte_o   = rx_byte_q;

endmodule : uart_bfm_rx

// File: rtl/uart_txrx_bfm.sv
// 8N1 UART bench peer: serial transmitter, receiver instance and received-line buffer.
module uart_txrx_bfm
   import uart_bfm_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4167,
   parameter int unsigned STR_LEN      = 512
) (
   input  logic            clock,
   input  logic            resetb,
   uart_txrx_bfm_if.slave  bus
);

   localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam int unsigned      IDX_W    = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam int unsigned      CW       = $clog2(STR_LEN + 1);
   localparam logic [CW-1:0]    CNT_FULL = CW'(STR_LEN - 1);

   logic [1:0]           tx_state_q, tx_state_d;
   logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
   logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
   logic                 ser_tx_q, ser_tx_d;
   logic                 tx_busy_q, tx_busy_d;
   logic                 tx_clear_q, tx_clear_d;

   logic                 rx_finish;
   logic [DATA_BITS-1:0] rx_byte;

   logic [CW-1:0]        count_q, count_d;
   logic                 flush_c;

   // TX state and datapath registers; reset drives the line idle at once
   always_ff @(posedge clock) begin
      if (!resetb) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shreg_q <= '0;
         ser_tx_q   <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_clear_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shreg_q <= tx_shreg_d;
         ser_tx_q   <= ser_tx_d;
         tx_busy_q  <= tx_busy_d;
         tx_clear_q <= tx_clear_d;
      end
   end

   // TX next state: shift register presents the next data bit in bit 1 at each bit boundary
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      tx_idx_d   = tx_idx_q;
      tx_shreg_d = tx_shreg_q;
      ser_tx_d   = ser_tx_q;
      tx_busy_d  = tx_busy_q;
      tx_clear_d = tx_clear_q;
      if (tx_clear_q && !bus.tx_start) tx_clear_d = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (bus.tx_start && !tx_clear_q) begin
               tx_state_d = TX_START;
               tx_shreg_d = bus.tx_data;
               ser_tx_d   = 1'b0;
               tx_busy_d  = 1'b1;
            end
         end
         TX_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               ser_tx_d   = tx_shreg_q[0];
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_idx_q == IDX_LAST) begin
                  ser_tx_d   = 1'b1;
                  tx_state_d = TX_STOP;
               end else begin
                  tx_idx_d   = tx_idx_q + 1'b1;
                  ser_tx_d   = tx_shreg_q[1];
                  tx_shreg_d = {1'b1, tx_shreg_q[DATA_BITS-1:1]};
               end
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
               tx_busy_d  = 1'b0;
               tx_clear_d = 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   uart_bfm_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk         (clock),
      .rst_n       (resetb),
      .ser_rx_i    (bus.ser_rx),
      .rx_finish_o (rx_finish),
      .rx_byte_o   (rx_byte)
   );

   // Line ends on LF or when the buffer fills; the count then restarts at 0
   assign flush_c = rx_finish && ((rx_byte == ASCII_LF) || (count_q == CNT_FULL));

   // Line-buffer fill count
   always_comb begin
      count_d = count_q;
      if (rx_finish) count_d = flush_c ? '0 : count_q + 1'b1;
   end

   // Line-buffer count register
   always_ff @(posedge clock) begin
      if (!resetb) count_q <= '0;
      else         count_q <= count_d;
   end

`ifndef SYNTHESIS
   logic [7:0]  line_q [2**CW];
   int unsigned print_cnt_q;

   // Simulation-only: store received characters and print each completed line
   always_ff @(posedge clock) begin
      if (!resetb) begin
         print_cnt_q <= 0;
      end else if (rx_finish) begin
         line_q[count_q] <= rx_byte;
         if (flush_c) begin
            $write("uart_bfm rx: ");
            for (int i = 0; i < int'(count_q); i++) $write("%c", line_q[CW'(i)]);
            if (rx_byte != ASCII_LF) $write("%c", rx_byte);
            $write("\n");
            print_cnt_q <= print_cnt_q + 1;
         end
      end
   end
`endif

   assign bus.ser_tx       = ser_tx_q;
   assign bus.tx_busy      = tx_busy_q;
   assign bus.tx_clear_req = tx_clear_q;
   assign bus.rx_finish    = rx_finish;
   assign bus.rx_byte      = rx_byte;

endmodule : uart_txrx_bfm

// File: tb/tb_uart_txrx_bfm.sv
// Directed bench for the UART peer: TX framing, reset abort, loopback, glitch, framing error, line buffer.
module tb_uart_txrx_bfm;
   import uart_bfm_pkg::*;

   localparam int unsigned CPB  = 8;
   localparam int unsigned STRL = 4;

   logic clock = 1'b0;
   logic resetb;
   logic tb_rx;
   logic loop_en;

   uart_txrx_bfm_if bus ();

   assign bus.ser_rx = loop_en ? bus.ser_tx : tb_rx;

   uart_txrx_bfm #(
      .CLKS_PER_BIT (CPB),
      .STR_LEN      (STRL)
   ) dut (
      .clock  (clock),
      .resetb (resetb),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned fin_cycles = 0;

   // Count cycles with rx_finish high (a one-cycle pulse adds exactly 1)
   always @(negedge clock) if (resetb === 1'b1 && bus.rx_finish === 1'b1) fin_cycles++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Request one byte and release tx_start once the frame has ended
   task automatic tx_byte(input logic [7:0] b);
      int k;
      @(negedge clock);
      bus.tx_data  = b;
      bus.tx_start = 1'b1;
      k = 0;
      while (bus.tx_clear_req !== 1'b1 && k < 400) begin
         tick(1);
         k++;
      end
      chk($sformatf("tx_done_%02h", b), 32'(k < 400), 32'd1);
      bus.tx_start = 1'b0;
      tick(2);
   endtask

   // Drive one serial frame directly onto ser_rx with a chosen stop-bit value
   task automatic rx_frame(input logic [7:0] b, input logic stop);
      @(negedge clock);
      tb_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         tb_rx = b[i];
         tick(CPB);
      end
      tb_rx = stop;
      tick(CPB);
      tb_rx = 1'b1;
      tick(CPB);
   endtask

   initial begin
      int          k;
      int unsigned busy_hi;
      int unsigned f0;
      logic [9:0]  frame;

      bus.tx_start = 1'b0;
      bus.tx_data  = 8'h00;
      tb_rx        = 1'b1;
      loop_en      = 1'b0;
      resetb       = 1'b0;
      tick(3);

      chk("rst_ser_tx",    32'(bus.ser_tx),       32'd1);
      chk("rst_tx_busy",   32'(bus.tx_busy),      32'd0);
      chk("rst_clear_req", 32'(bus.tx_clear_req), 32'd0);
      chk("rst_rx_finish", 32'(bus.rx_finish),    32'd0);
      chk("rst_rx_byte",   32'(bus.rx_byte),      32'h00);
      chk("rst_count",     32'(dut.count_q),      32'd0);

      // Transmit 0x0F with tx_start held high
      resetb       = 1'b1;
      bus.tx_data  = 8'h0F;
      bus.tx_start = 1'b1;
      k = 0;
      while (bus.tx_busy !== 1'b1 && k < 4) begin
         tick(1);
         k++;
      end
      chk("busy_latency", 32'(k <= 2 && bus.tx_busy === 1'b1), 32'd1);

      frame   = {1'b1, 8'h0F, 1'b0};
      busy_hi = 0;
      for (int i = 0; i < 80; i++) begin
         if (bus.tx_busy === 1'b1) busy_hi++;
         if (i % 8 == 4) chk($sformatf("tx_bit%0d", i / 8), 32'(bus.ser_tx), 32'(frame[4'(i / 8)]));
         if (i == 20) bus.tx_data = 8'hFF;
         tick(1);
      end
      chk("busy_len",  busy_hi,                   32'd80);
      chk("busy_end",  32'(bus.tx_busy),          32'd0);
      chk("clear_set", 32'(bus.tx_clear_req),     32'd1);
      chk("idle_line", 32'(bus.ser_tx),           32'd1);

      busy_hi = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.tx_busy === 1'b1) busy_hi++;
         tick(1);
      end
      chk("no_second_frame", busy_hi,               32'd0);
      chk("clear_held",      32'(bus.tx_clear_req), 32'd1);
      bus.tx_start = 1'b0;
      tick(1);
      chk("clear_drop", 32'(bus.tx_clear_req), 32'd0);

      // Reset in the middle of a frame (data bit 2 of 0xC3 is 0)
      bus.tx_data  = 8'hC3;
      bus.tx_start = 1'b1;
      tick(31);
      chk("mid_state",   32'(dut.tx_state_q), 32'(TX_DATA));
      chk("mid_line_lo", 32'(bus.ser_tx),     32'd0);
      resetb       = 1'b0;
      bus.tx_start = 1'b0;
      tick(1);
      chk("abort_ser_tx", 32'(bus.ser_tx),  32'd1);
      chk("abort_busy",   32'(bus.tx_busy), 32'd0);
      resetb = 1'b1;
      tick(2);

      // Loopback two frames
      loop_en = 1'b1;
      f0 = fin_cycles;
      tx_byte(8'h3D);
      chk("lb_byte0", 32'(bus.rx_byte), 32'h3D);
      tx_byte(8'h0F);
      chk("lb_byte1",  32'(bus.rx_byte), 32'h0F);
      chk("lb_pulses", fin_cycles - f0,  32'd2);

      // Two-cycle low glitch must be rejected
      loop_en = 1'b0;
      f0 = fin_cycles;
      tick(1);
      tb_rx = 1'b0;
      tick(2);
      tb_rx = 1'b1;
      tick(20);
      chk("glitch_pulses", fin_cycles - f0,          32'd0);
      chk("glitch_idle",   32'(dut.u_rx.state_q),    32'(RX_IDLE));
      rx_frame(8'hA5, 1'b1);
      chk("a5_pulse", fin_cycles - f0,  32'd1);
      chk("a5_byte",  32'(bus.rx_byte), 32'hA5);

      // Framing error: stop bit 0
      f0 = fin_cycles;
      rx_frame(8'h55, 1'b0);
      tick(5);
      chk("fe_pulses", fin_cycles - f0,  32'd0);
      chk("fe_byte",   32'(bus.rx_byte), 32'hA5);

      // Line buffer: "Hi\n", then five non-LF bytes with a 4-byte buffer
      resetb = 1'b0;
      tick(1);
      resetb  = 1'b1;
      loop_en = 1'b1;
      tick(2);
      chk("buf_rst_count", 32'(dut.count_q), 32'd0);
      f0 = fin_cycles;
      tx_byte(8'h48);
      tx_byte(8'h69);
      chk("hi_count", 32'(dut.count_q), 32'd2);
      tx_byte(ASCII_LF);
      chk("lf_pulses", fin_cycles - f0,      32'd3);
      chk("lf_count",  32'(dut.count_q),     32'd0);
      chk("lf_prints", dut.print_cnt_q,      32'd1);
      for (int i = 0; i < 4; i++) tx_byte(8'h61 + 8'(i));
      chk("full_count",  32'(dut.count_q), 32'd0);
      chk("full_prints", dut.print_cnt_q,  32'd2);
      tx_byte(8'h65);
      chk("wrap_count",  32'(dut.count_q), 32'd1);
      chk("wrap_prints", dut.print_cnt_q,  32'd2);
      chk("wrap_byte",   32'(bus.rx_byte), 32'h65);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_uart_txrx_bfm

// File: doc/uart_txrx_bfm.md
Name: uart_txrx_bfm

Overview:
Synchronous 8N1 UART peer used as a bench model alongside the Caravel SoC. It serially transmits bytes requested by the bench on ser_tx, which connects to the chip's UART RX pin. It receives bytes from the chip's UART TX pin on ser_rx, signalling rx_finish per received byte. Received bytes are collected into a line buffer and printed in simulation.

Parameters:
CLKS_PER_BIT, 4167, clock cycles per UART bit (9600 baud at 40 MHz); legal range ≥ 4.
STR_LEN, 512, receive line-buffer depth in bytes.

Ports:
clock  in  1  system clock; all logic is rising-edge.
resetb  in  1  reset; synchronous and active-low.
ser_rx  in  1  serial input from the DUT TX pin; idles high.
ser_tx  out  1  serial output to the DUT RX pin; idles high.
tx_start  in  1  level request to send tx_data.
tx_data  in  8  byte to send; sampled when the frame is accepted.
tx_busy  out  1  high while a frame is on ser_tx.
tx_clear_req  out  1  high from frame end until tx_start is seen low.
rx_finish  out  1  one-cycle pulse per good received byte.
rx_byte  out  8  last good received byte; held until the next one.

Behaviour:
- Reset (resetb=0 at a clock edge) forces:
  - ser_tx=1; tx_busy=0; tx_clear_req=0; rx_finish=0; rx_byte=0.
  - Both FSMs go to IDLE and the buffer count goes to 0.
  - A reset mid-frame aborts the frame and the line returns high immediately.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when tx_start=1 and tx_clear_req=0: latch tx_data, tx_busy=1 from the next cycle.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Bit order: start bit 0, then data bits LSB first, then stop bit 1.
  - At the end of the stop bit: tx_busy=0 and tx_clear_req=1 in the same cycle; return to IDLE.
  - tx_clear_req clears on the first cycle tx_start=0. No new frame starts while it is high, so a held tx_start sends exactly one byte.
  - tx_data changes while busy are ignored.
- RX path:
  - ser_rx passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling edge.
  - At half a bit period, if the line is high again the event is a glitch: return to IDLE with no output.
  - Otherwise sample 8 data bits LSB first at mid-bit, each one CLKS_PER_BIT apart, then sample the stop bit at mid-bit.
  - Stop bit = 1: rx_byte updates and rx_finish pulses for 1 cycle, in the same cycle as the stop-bit sample.
  - Stop bit = 0 (framing error): discard the byte, no pulse.
  - Return to IDLE directly after the stop-bit sample, so back-to-back frames are received.
- TX and RX are fully independent; simultaneous operation is required. Loopback of ser_tx to ser_rx must work.
- Line buffer:
  - Each good byte is appended at index count; count increments.
  - When the byte is 0x0A, or count reaches STR_LEN, the buffer is printed with $display and count resets to 0.
  - Printing is simulation-only logic guarded by translate_off; count wraps, never overflows.

Decomposition:
- Package uart_bfm_pkg holds:
  - TX and RX state enums;
  - DATA_BITS=8;
  - ASCII_LF=8'h0A.
- One natural sub-module, uart_bfm_rx (synchronizer, RX FSM, bit counter). The TX FSM and line buffer stay in the top module.

Test Plan:
- Reset mid-frame: assert resetb=0 during the DATA state of a TX frame → ser_tx=1 and tx_busy=0 after the edge; a fresh tx_start then transmits correctly.
- CLKS_PER_BIT=8, tx_data=8'h0F, tx_start held high → tx_busy rises within 2 cycles.
  - ser_tx carries 0,1,1,1,1,0,0,0,0,1, each bit 8 cycles; tx_busy high for 80 cycles.
  - tx_clear_req stays 1 until tx_start drops, and there is no second frame.
- Loopback ser_tx→ser_rx, send 8'h3D then 8'h0F → rx_finish pulses twice (one cycle each); rx_byte=8'h3D then 8'h0F.
- Glitch: drive ser_rx low for 2 cycles (CLKS_PER_BIT=8) → no rx_finish, RX back in IDLE; a following valid 8'hA5 frame is received.
- Framing error: drive a frame for 8'h55 with stop bit 0 → no rx_finish, rx_byte unchanged.
- Loopback "Hi\n" (0x48,0x69,0x0A) → three rx_finish pulses, buffer printed once, count returns to 0. With STR_LEN=4 and 5 non-LF bytes → print after the 4th byte, count=1 after the 5th.
